// File: rtl/signed_seq_multiplier.sv
// signed_seq_multiplier
//   Shift-add sequential multiplier with a runtime signed/unsigned mode.
//   The operands are reduced to magnitudes when the operation is accepted.
//   One multiplier bit is consumed per cycle, LSB first, for exactly LENGTH cycles.
//   A final FIX cycle restores the sign. The latency does not depend on the data.
//
// Ports
//   clock         system clock, rising edge
//   reset         synchronous, active-high; clears all state and outputs
//   start         request, taken in IDLE, or in DONE once Ready is showing
//   signed_mode   1 = operands are two's complement, 0 = unsigned
//   multiplier    operand A (LENGTH bits)
//   multiplicand  operand B (LENGTH bits)
//   product       registered 2*LENGTH-bit result
//   Computing     high while an operation is in progress (CALC and FIX)
//   Ready         high while product holds a finished result
//   Negative      set when a signed result is below zero
//
// Computing and Ready are registered and follow the state by one cycle.
// As a result:
//   - start accepted at edge k raises Computing at edge k+1;
//   - Ready rises at edge k+LENGTH+2.
// In DONE, start is only taken once Ready is visible. This guarantees that
// every result is presented for at least one cycle. A start held high
// therefore restarts every LENGTH+3 cycles.
module signed_seq_multiplier #(
  parameter int LENGTH = 8,
  parameter int CNT_W  = $clog2(LENGTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [LENGTH-1:0]     multiplier,
  input  logic [LENGTH-1:0]     multiplicand,
  output logic [2*LENGTH-1:0]   product,
  output logic                  Computing,
  output logic                  Ready,
  output logic                  Negative
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state, state_n;
  logic [LENGTH-1:0]     a_q;      // remaining multiplier bits, shifted right each CALC cycle
  logic [2*LENGTH-1:0]   bsh_q;    // |B| << counter, shifted left each CALC cycle
  logic [2*LENGTH-1:0]   acc_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  sign_q;
  logic                  accept;

  // |v| as an unsigned LENGTH-bit value. -2^(LENGTH-1) negates to itself,
  // which read as unsigned is exactly 2^(LENGTH-1).
  function automatic logic [LENGTH-1:0] magnitude(input logic signed [LENGTH-1:0] v,
                                                  input logic                     is_signed);
    if (is_signed && v[LENGTH-1])
      return -v;
    else
      return v;
  endfunction

  function automatic logic [2*LENGTH-1:0] apply_sign(input logic [2*LENGTH-1:0] mag,
                                                     input logic                neg);
    return neg ? -mag : mag;
  endfunction

  assign accept = start && ((state == IDLE) || ((state == DONE) && Ready));

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (accept) state_n = CALC;
      CALC:       if (cnt_q == CNT_W'(LENGTH - 1)) state_n = FIX;
      FIX:        state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      a_q       <= '0;
      bsh_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      product   <= '0;
      Negative  <= 1'b0;
      Computing <= 1'b0;
      Ready     <= 1'b0;
    end else begin
      state     <= state_n;
      Computing <= (state == CALC) || (state == FIX);
      Ready     <= (state == DONE) && !accept;

      // load: operands reduced to magnitudes, sign kept aside
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_q    <= magnitude(multiplier, signed_mode);
            bsh_q  <= {{LENGTH{1'b0}}, magnitude(multiplicand, signed_mode)};
            sign_q <= signed_mode && (multiplier[LENGTH-1] ^ multiplicand[LENGTH-1]);
            acc_q  <= '0;
            cnt_q  <= '0;
          end
        end
        // accumulate: one multiplier bit per cycle; magnitudes cannot overflow 2*LENGTH bits
        CALC: begin
          if (a_q[0])
            acc_q <= acc_q + bsh_q;
          a_q   <= a_q >> 1;
          bsh_q <= bsh_q << 1;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        // fix: restore the sign; a zero magnitude never reports Negative
        FIX: begin
          product  <= apply_sign(acc_q, sign_q);
          Negative <= sign_q && (acc_q != '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_multiplier.sv
// Directed bench for signed_seq_multiplier at LENGTH = 4, 8 and 16.
// Instance widths share clock and reset. Each has its own operand/start inputs.
module tb_signed_seq_multiplier;

  logic clock;
  logic reset;

  logic        st4, sm4;  logic [3:0]  a4, b4;  logic [7:0]  pr4;  logic cp4, rd4, ng4;
  logic        st8, sm8;  logic [7:0]  a8, b8;  logic [15:0] pr8;  logic cp8, rd8, ng8;
  logic        st16, sm16; logic [15:0] a16, b16; logic [31:0] pr16; logic cp16, rd16, ng16;

  int total = 0;
  int bad   = 0;

  signed_seq_multiplier #(.LENGTH(4)) dut4 (
    .clock(clock), .reset(reset), .start(st4), .signed_mode(sm4),
    .multiplier(a4), .multiplicand(b4), .product(pr4),
    .Computing(cp4), .Ready(rd4), .Negative(ng4));

  signed_seq_multiplier #(.LENGTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(st8), .signed_mode(sm8),
    .multiplier(a8), .multiplicand(b8), .product(pr8),
    .Computing(cp8), .Ready(rd8), .Negative(ng8));

  signed_seq_multiplier #(.LENGTH(16)) dut16 (
    .clock(clock), .reset(reset), .start(st16), .signed_mode(sm16),
    .multiplier(a16), .multiplicand(b16), .product(pr16),
    .Computing(cp16), .Ready(rd16), .Negative(ng16));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic rdy(input int w);
    return (w == 4) ? rd4 : (w == 8) ? rd8 : rd16;
  endfunction

  function automatic logic cmp(input int w);
    return (w == 4) ? cp4 : (w == 8) ? cp8 : cp16;
  endfunction

  function automatic logic [31:0] prd(input int w);
    return (w == 4) ? {24'h0, pr4} : (w == 8) ? {16'h0, pr8} : pr16;
  endfunction

  function automatic logic ngt(input int w);
    return (w == 4) ? ng4 : (w == 8) ? ng8 : ng16;
  endfunction

  // Issue one operation on instance w, starting at #1 after an edge.
  // lat  = edges after the accepting edge until Ready is seen (-1 on timeout).
  // comp = Computing samples at those edges.
  // rk   = Ready just after the accepting edge.
  task automatic op(input int w, input logic sm, input logic [15:0] a, input logic [15:0] b,
                    output logic [31:0] p, output logic neg, output int lat,
                    output int comp, output logic rk);
    case (w)
      4:       begin st4 = 1'b1;  sm4 = sm;  a4 = a[3:0];  b4 = b[3:0];  end
      8:       begin st8 = 1'b1;  sm8 = sm;  a8 = a[7:0];  b8 = b[7:0];  end
      default: begin st16 = 1'b1; sm16 = sm; a16 = a;      b16 = b;      end
    endcase
    @(posedge clock); #1;
    rk = rdy(w);
    st4 = 1'b0; st8 = 1'b0; st16 = 1'b0;
    comp = 0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (cmp(w)) comp++;
      if (rdy(w)) begin
        lat = i;
        break;
      end
    end
    p = prd(w);
    neg = ngt(w);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++; if (pr8 !== 16'h0) begin bad++; $display("FAIL reset_prod8 got=%h exp=0000", pr8); end
    total++; if ({cp8, rd8, ng8} !== 3'b000) begin bad++; $display("FAIL reset_flags8 got=%b exp=000", {cp8, rd8, ng8}); end
    total++; if ({pr4, cp4, rd4, ng4} !== 11'h0) begin bad++; $display("FAIL reset_4 got=%h exp=0", {pr4, cp4, rd4, ng4}); end
    total++; if ({pr16, cp16, rd16, ng16} !== 35'h0) begin bad++; $display("FAIL reset_16 got=%h exp=0", {pr16, cp16, rd16, ng16}); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_unsigned_basic();
    logic [31:0] p; logic n, rk; int lat, comp;
    op(8, 1'b0, 16'd8, 16'd3, p, n, lat, comp, rk);
    total++; if (p !== 32'h18) begin bad++; $display("FAIL t1_prod got=%h exp=%h", p, 32'h18); end
    total++; if (n !== 1'b0) begin bad++; $display("FAIL t1_neg got=%b exp=0", n); end
    total++; if (lat !== 10) begin bad++; $display("FAIL t1_latency got=%0d exp=10", lat); end
    total++; if (comp !== 9) begin bad++; $display("FAIL t1_computing_cycles got=%0d exp=9", comp); end
  endtask

  task automatic test_signed_mode();
    logic [31:0] p; logic n, rk; int lat, comp;
    op(8, 1'b1, 16'h00FB, 16'h0007, p, n, lat, comp, rk);
    total++; if (p !== 32'hFFDD) begin bad++; $display("FAIL t2_signed_prod got=%h exp=%h", p, 32'hFFDD); end
    total++; if (n !== 1'b1) begin bad++; $display("FAIL t2_signed_neg got=%b exp=1", n); end
    op(8, 1'b0, 16'h00FB, 16'h0007, p, n, lat, comp, rk);
    total++; if (p !== 32'h06DD) begin bad++; $display("FAIL t2_unsigned_prod got=%h exp=%h", p, 32'h06DD); end
    total++; if (n !== 1'b0) begin bad++; $display("FAIL t2_unsigned_neg got=%b exp=0", n); end
  endtask

  task automatic test_extremes();
    logic [31:0] p; logic n, rk; int lat, comp;
    op(8, 1'b0, 16'h00FF, 16'h00FF, p, n, lat, comp, rk);
    total++; if (p !== 32'hFE01) begin bad++; $display("FAIL t3_ffxff got=%h exp=%h", p, 32'hFE01); end
    op(8, 1'b1, 16'h0080, 16'h0080, p, n, lat, comp, rk);
    total++; if ({n, p} !== {1'b0, 32'h4000}) begin bad++; $display("FAIL t3_80x80 got=%b/%h exp=0/%h", n, p, 32'h4000); end
    op(8, 1'b1, 16'h0080, 16'h0001, p, n, lat, comp, rk);
    total++; if ({n, p} !== {1'b1, 32'hFF80}) begin bad++; $display("FAIL t3_80x01 got=%b/%h exp=1/%h", n, p, 32'hFF80); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p; logic n, rk; int lat, comp;
    op(8, 1'b1, 16'h0000, 16'h00FF, p, n, lat, comp, rk);
    total++; if ({n, p} !== {1'b0, 32'h0}) begin bad++; $display("FAIL t4_zero got=%b/%h exp=0/0", n, p); end
    total++; if (lat !== 10) begin bad++; $display("FAIL t4_zero_latency got=%0d exp=10", lat); end
    // Ready is high here; the next start is taken straight from DONE
    op(8, 1'b0, 16'd2, 16'd3, p, n, lat, comp, rk);
    total++; if (rk !== 1'b0) begin bad++; $display("FAIL t4_ready_drop got=%b exp=0", rk); end
    total++; if (p !== 32'h6) begin bad++; $display("FAIL t4_prod got=%h exp=%h", p, 32'h6); end
    total++; if (lat !== 10) begin bad++; $display("FAIL t4_latency got=%0d exp=10", lat); end
  endtask

  task automatic test_ignore_start();
    int lat;
    sm8 = 1'b0; a8 = 8'd9; b8 = 8'd9; st8 = 1'b1;
    @(posedge clock); #1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      st8 = (i <= 4) ? i[0] : 1'b0;
      a8 = 8'd1; b8 = 8'd1; sm8 = 1'b1;
      @(posedge clock); #1;
      if (rd8) begin
        lat = i;
        break;
      end
    end
    st8 = 1'b0;
    total++; if (pr8 !== 16'h0051) begin bad++; $display("FAIL t5_prod got=%h exp=0051", pr8); end
    total++; if (lat !== 10) begin bad++; $display("FAIL t5_latency got=%0d exp=10", lat); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] p; logic n, rk; int lat, comp;
    sm8 = 1'b0; a8 = 8'd5; b8 = 8'd6; st8 = 1'b1;
    @(posedge clock); #1;
    st8 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1; st8 = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; st8 = 1'b0;
    total++; if ({pr8, cp8, rd8, ng8} !== 19'h0) begin bad++; $display("FAIL t6_after_reset got=%h exp=0", {pr8, cp8, rd8, ng8}); end
    @(posedge clock); #1;
    total++; if ({cp8, rd8} !== 2'b00) begin bad++; $display("FAIL t6_idle got=%b exp=00", {cp8, rd8}); end
    op(8, 1'b0, 16'd5, 16'd5, p, n, lat, comp, rk);
    total++; if (p !== 32'd25) begin bad++; $display("FAIL t6_prod got=%h exp=%h", p, 32'd25); end
    total++; if (lat !== 10) begin bad++; $display("FAIL t6_latency got=%0d exp=10", lat); end
  endtask

  task automatic test_widths();
    logic [31:0] p; logic n, rk; int lat, comp;
    logic        sm_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [15:0] a4_t [5] = '{16'h8, 16'hB, 16'hF, 16'h8, 16'h8};
    logic [15:0] b4_t [5] = '{16'h3, 16'h7, 16'hF, 16'h8, 16'h1};
    logic [31:0] e4_t [5] = '{32'h18, 32'hDD, 32'hE1, 32'h40, 32'hF8};
    logic [15:0] a16_t[5] = '{16'h8, 16'hFFFB, 16'hFFFF, 16'h8000, 16'h8000};
    logic [15:0] b16_t[5] = '{16'h3, 16'h7, 16'hFFFF, 16'h8000, 16'h1};
    logic [31:0] e16_t[5] = '{32'h18, 32'hFFFFFFDD, 32'hFFFE0001, 32'h40000000, 32'hFFFF8000};
    logic        n_t  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      op(4, sm_t[i], a4_t[i], b4_t[i], p, n, lat, comp, rk);
      total++; if ({n, p} !== {n_t[i], e4_t[i]}) begin bad++; $display("FAIL w4_case%0d got=%b/%h exp=%b/%h", i, n, p, n_t[i], e4_t[i]); end
      if (i == 0) begin
        total++; if ({lat, comp} !== {32'd6, 32'd5}) begin bad++; $display("FAIL w4_timing got=%0d/%0d exp=6/5", lat, comp); end
      end
      op(16, sm_t[i], a16_t[i], b16_t[i], p, n, lat, comp, rk);
      total++; if ({n, p} !== {n_t[i], e16_t[i]}) begin bad++; $display("FAIL w16_case%0d got=%b/%h exp=%b/%h", i, n, p, n_t[i], e16_t[i]); end
      if (i == 0) begin
        total++; if ({lat, comp} !== {32'd18, 32'd17}) begin bad++; $display("FAIL w16_timing got=%0d/%0d exp=18/17", lat, comp); end
      end
    end
    // unsigned view of the 4-bit -5 x 7 operands
    op(4, 1'b0, 16'hB, 16'h7, p, n, lat, comp, rk);
    total++; if ({n, p} !== {1'b0, 32'h4D}) begin bad++; $display("FAIL w4_unsigned got=%b/%h exp=0/%h", n, p, 32'h4D); end
    op(16, 1'b0, 16'hFFFB, 16'h7, p, n, lat, comp, rk);
    total++; if ({n, p} !== {1'b0, 32'h0006FFDD}) begin bad++; $display("FAIL w16_unsigned got=%b/%h exp=0/%h", n, p, 32'h0006FFDD); end
  endtask

  initial begin
    reset = 1'b1;
    st4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    st8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    st16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    test_reset();
    test_unsigned_basic();
    test_signed_mode();
    test_extremes();
    test_back_to_back();
    test_ignore_start();
    test_mid_reset();
    test_widths();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
